// File: rtl/wifi_at_pkg.sv
// Shared types, command ROM and ASCII helpers for the ESP8266 AT sequencer.
package wifi_at_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST     = 3'd1,
    ST_BOOT    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_OK = 3'd4,
    ST_READY   = 3'd5,
    ST_REPORT  = 3'd6,
    ST_FAIL    = 3'd7
  } state_e;

  // Which message is currently being streamed / awaiting OK.
  typedef enum logic [1:0] {
    CMD_AT   = 2'd0,
    CMD_ATE0 = 2'd1,
    CMD_RPT  = 2'd2
  } cmd_e;

  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_EQ = 8'h3D;

  localparam logic [31:0] OK_WORD = {ASCII_O, ASCII_K, ASCII_CR, ASCII_LF};

  // Init script "AT\r\n" followed by "ATE0\r\n"; element 0 is the first byte sent.
  localparam int CMD_ROM_DEPTH = 10;
  localparam logic [CMD_ROM_DEPTH-1:0][7:0] CMD_ROM = {
    ASCII_LF, ASCII_CR, 8'h30, 8'h45, 8'h54, 8'h41,
    ASCII_LF, ASCII_CR, 8'h54, 8'h41
  };

  localparam logic [3:0] CMD_AT_START   = 4'd0;
  localparam logic [3:0] CMD_ATE0_START = 4'd4;
  localparam logic [2:0] CMD_AT_LEN     = 3'd4;
  localparam logic [2:0] CMD_ATE0_LEN   = 3'd6;
  localparam logic [2:0] CMD_RPT_LEN    = 3'd5;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [2:0] cmd_len(input cmd_e cmd);
    case (cmd)
      CMD_AT:   return CMD_AT_LEN;
      CMD_ATE0: return CMD_ATE0_LEN;
      default:  return CMD_RPT_LEN;
    endcase
  endfunction

  // Byte idx of the given message; the report is "S=<hex>\r\n".
  function automatic logic [7:0] msg_byte(input cmd_e cmd, input logic [2:0] idx,
                                          input logic [3:0] snap);
    logic [7:0] b;
    b = 8'h00;
    case (cmd)
      CMD_AT:   b = CMD_ROM[CMD_AT_START + {1'b0, idx}];
      CMD_ATE0: b = CMD_ROM[CMD_ATE0_START + {1'b0, idx}];
      default: begin
        case (idx)
          3'd0:    b = ASCII_S;
          3'd1:    b = ASCII_EQ;
          3'd2:    b = hex_to_ascii(snap);
          3'd3:    b = ASCII_CR;
          default: b = ASCII_LF;
        endcase
      end
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wifi_at_sequencer_matcher.sv
// Detects "OK\r\n" in the rx byte stream; match pulses on the cycle the LF arrives.
module wifi_ok_matcher
  import wifi_at_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       match_o
);

  // The three previous bytes plus the incoming byte form the 4-byte window.
  logic [23:0] shift_q;

  // Shift accepted rx bytes; clearing drops any partial match.
  always_ff @(posedge clk) begin
    if (srst || clear_i) begin
      shift_q <= '0;
    end else if (en_i && rx_valid_i) begin
      shift_q <= {shift_q[15:0], rx_data_i};
    end
  end

  // Combinational so the sequencer can act in the same cycle the LF is received.
  always_comb begin
    match_o = en_i && rx_valid_i && ({shift_q, rx_data_i} == OK_WORD);
  end

endmodule

// File: rtl/wifi_at_sequencer.sv
// ESP8266 bring-up sequencer: reset pulse, boot wait, AT init script with OK
// confirmation/retry, then ASCII reports of switch changes.
module wifi_at_sequencer
  import wifi_at_pkg::*;
#(
  parameter int RESET_CYCLES   = 5_000_000,
  parameter int BOOT_CYCLES    = 100_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       start,
  input  logic [3:0] sw,
  output logic       wifi_reset_n,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       cts_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ready,
  output logic       error,
  output logic [2:0] state_dbg
);

  localparam logic [31:0] RST_LAST   = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] BOOT_LAST  = 32'(BOOT_CYCLES - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  snap_q, snap_d;
  logic [3:0]  last_sent_q, last_sent_d;
  logic [3:0]  sw_meta_q, sw_sync_q;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic        wifi_rst_n_q, wifi_rst_n_d;

  logic        ok_match;
  logic        last_byte;
  logic [7:0]  cur_byte, next_byte;

  wifi_ok_matcher u_matcher (
    .clk        (clk_clk),
    .srst       (reset_reset),
    .clear_i    (start || (state_q != ST_WAIT_OK)),
    .en_i       ((state_q == ST_WAIT_OK) && !start),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .match_o    (ok_match)
  );

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Next-state, counter and registered-output logic of the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q + 32'd1;
    retry_d      = retry_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    last_sent_d  = last_sent_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    ready_d      = ready_q;
    error_d      = error_q;
    cur_byte     = msg_byte(cmd_q, idx_q, snap_q);
    next_byte    = msg_byte(cmd_q, idx_q + 3'd1, snap_q);
    last_byte    = (idx_q == cmd_len(cmd_q) - 3'd1);

    case (state_q)
      ST_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_BOOT;
      end
      ST_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = ST_SEND;
          cmd_d   = CMD_AT;
          idx_d   = '0;
        end
      end
      ST_SEND, ST_REPORT: begin
        // A presented byte is held until accepted; new bytes only start while CTS is low.
        if (tx_valid_q) begin
          if (tx_ready) begin
            if (last_byte) begin
              tx_valid_d = 1'b0;
              state_d    = ST_WAIT_OK;
            end else begin
              idx_d      = idx_q + 3'd1;
              tx_valid_d = !cts_n;
              tx_data_d  = next_byte;
            end
          end
        end else if (!cts_n) begin
          tx_valid_d = 1'b1;
          tx_data_d  = cur_byte;
        end
      end
      ST_WAIT_OK: begin
        // An OK arriving on the timeout cycle still counts as success.
        if (ok_match) begin
          retry_d = '0;
          if (cmd_q == CMD_AT) begin
            cmd_d   = CMD_ATE0;
            idx_d   = '0;
            state_d = ST_SEND;
          end else if (cmd_q == CMD_ATE0) begin
            state_d = ST_READY;
            ready_d = 1'b1;
          end else begin
            last_sent_d = snap_q;
            state_d     = ST_READY;
          end
        end else if (cnt_q == TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 8'd1;
            idx_d   = '0;
            state_d = (cmd_q == CMD_RPT) ? ST_REPORT : ST_SEND;
          end else begin
            state_d = ST_FAIL;
            error_d = 1'b1;
            ready_d = 1'b0;
          end
        end
      end
      ST_READY: begin
        if (sw_sync_q != last_sent_q) begin
          snap_d  = sw_sync_q;
          cmd_d   = CMD_RPT;
          idx_d   = '0;
          state_d = ST_REPORT;
        end
      end
      default: begin
      end
    endcase

    // start overrides every other event and withdraws any pending byte.
    if (start) begin
      state_d    = ST_RST;
      retry_d    = '0;
      error_d    = 1'b0;
      ready_d    = 1'b0;
      tx_valid_d = 1'b0;
      idx_d      = '0;
    end

    // The shared counter restarts on every state change and idles outside timed states.
    if (start || (state_d != state_q) ||
        !(state_q == ST_RST || state_q == ST_BOOT || state_q == ST_WAIT_OK)) begin
      cnt_d = '0;
    end

    wifi_rst_n_d = (state_d != ST_RST);
  end

  // State and output registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= CMD_AT;
      cnt_q        <= '0;
      retry_q      <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      last_sent_q  <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      wifi_rst_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      last_sent_q  <= last_sent_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      wifi_rst_n_q <= wifi_rst_n_d;
    end
  end

  assign wifi_reset_n = wifi_rst_n_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign ready        = ready_q;
  assign error        = error_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_wifi_at_sequencer.sv
// Directed bench for wifi_at_sequencer with a TX byte scoreboard.
module tb_wifi_at_sequencer;

  logic       clk = 1'b0;
  logic       reset_reset, start, tx_ready, cts_n, rx_valid;
  logic [3:0] sw;
  logic [7:0] rx_data;
  logic       wifi_reset_n, tx_valid, ready, error;
  logic [7:0] tx_data;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  wifi_at_sequencer #(
    .RESET_CYCLES   (4),
    .BOOT_CYCLES    (8),
    .TIMEOUT_CYCLES (20),
    .MAX_RETRY      (2)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .start        (start),
    .sw           (sw),
    .wifi_reset_n (wifi_reset_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .cts_n        (cts_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .ready        (ready),
    .error        (error),
    .state_dbg    (state_dbg)
  );

  // Monitor: every accepted TX byte is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!reset_reset && tx_valid && tx_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got byte %02h, required no byte", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          n_err++;
          $display("FAIL tx_byte: got %02h, required %02h", tx_data, e);
        end else begin
          $display("tx byte %02h matched", tx_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
    int n;
    n = 0;
    while (state_dbg !== s && n < max_cyc) begin
      tick();
      n++;
    end
    if (state_dbg !== s) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: state %0d, required %0d within %0d cycles", name, state_dbg, s, max_cyc);
    end
  endtask

  task automatic push_msg(input string body);
    for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic rx_ok();
    rx_byte(8'h4F); rx_byte(8'h4B); rx_byte(8'h0D); rx_byte(8'h0A);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset_reset = 1'b1; start = 1'b0; sw = 4'h0; tx_ready = 1'b1; cts_n = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    reset_reset = 1'b0;

    // Reset values
    check("rst_state", state_dbg, 0);
    check("rst_wifi_reset_n", wifi_reset_n, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ready", ready, 0);
    check("rst_error", error, 0);

    // Init sequence: reset pulse width, AT then ATE0, each answered with OK
    push_msg("AT");
    pulse_start();
    check("start_state_rst", state_dbg, 1);
    n = 0;
    while (wifi_reset_n == 1'b0 && n < 100) begin n++; tick(); end
    check("reset_low_cycles", n, 4);
    wait_state(3'd4, 100, "init_wait_at");
    push_msg("ATE0");
    rx_ok();
    wait_state(3'd4, 50, "init_wait_ate0");
    rx_ok();
    wait_state(3'd5, 20, "init_ready");
    check("init_ready_flag", ready, 1);
    check("init_state_ready", state_dbg, 5);

    // Switch report sw=A, with 2+1 cycle detection latency
    push_msg("S=A");
    sw = 4'hA;
    tick(); tick();
    check("sw_latency_still_ready", state_dbg, 5);
    tick();
    check("sw_latency_report", state_dbg, 6);
    wait_state(3'd4, 50, "rpt_a_wait");
    rx_ok();
    wait_state(3'd5, 20, "rpt_a_ready");
    repeat (30) tick();
    check("sw_stable_no_tx_state", state_dbg, 5);
    check("sw_stable_tx_valid", tx_valid, 0);

    // Flow control: cts_n high blocks TX; tx_ready low holds the byte
    cts_n = 1'b1;
    push_msg("S=3");
    sw = 4'h3;
    wait_state(3'd6, 20, "cts_report");
    for (int i = 0; i < 6; i++) begin
      check("cts_block_valid", tx_valid, 0);
      tick();
    end
    tx_ready = 1'b0;
    cts_n = 1'b0;
    tick();
    check("cts_release_valid", tx_valid, 1);
    cts_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", tx_valid, 1);
      check("hold_data", tx_data, 8'h53);
      tick();
    end
    tx_ready = 1'b1;
    cts_n = 1'b0;
    wait_state(3'd4, 50, "cts_wait_ok");
    rx_ok();
    wait_state(3'd5, 20, "cts_ready");

    // Matcher: "OK\r" + garbage must not match; only the final LF completes
    push_msg("S=5");
    sw = 4'h5;
    wait_state(3'd4, 50, "garbage_wait");
    rx_byte(8'h4F); rx_byte(8'h4B); rx_byte(8'h0D); rx_byte(8'h78);
    check("garbage_no_match", state_dbg, 4);
    rx_byte(8'h4F); rx_byte(8'h4B); rx_byte(8'h0D);
    check("partial_no_match", state_dbg, 4);
    rx_byte(8'h0A);
    check("lf_match", state_dbg, 5);

    // OK finishing on the timeout cycle is a success
    push_msg("S=C");
    sw = 4'hC;
    wait_state(3'd4, 50, "edge_wait");
    repeat (16) tick();
    rx_ok();
    check("ok_on_timeout_wins", state_dbg, 5);
    check("ok_on_timeout_error", error, 0);

    // start mid-REPORT withdraws the pending byte; last_sent stays C
    tx_ready = 1'b0;
    sw = 4'h9;
    wait_state(3'd6, 20, "abort_report");
    tick();
    check("abort_pending_valid", tx_valid, 1);
    pulse_start();
    check("abort_tx_valid_drop", tx_valid, 0);
    check("abort_state_rst", state_dbg, 1);
    check("abort_wifi_reset_n", wifi_reset_n, 0);
    sw = 4'hC;
    tx_ready = 1'b1;
    push_msg("AT");
    wait_state(3'd4, 100, "reinit_wait_at");
    push_msg("ATE0");
    rx_ok();
    wait_state(3'd4, 50, "reinit_wait_ate0");
    rx_ok();
    wait_state(3'd5, 20, "reinit_ready");
    repeat (20) tick();
    check("last_sent_kept_state", state_dbg, 5);

    // No reply: AT sent 3 times, 20 WAIT_OK cycles each, then FAIL
    push_msg("AT"); push_msg("AT"); push_msg("AT");
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_state(3'd4, 100, "retry_wait");
      n = 0;
      while (state_dbg == 3'd4 && n < 100) begin n++; tick(); end
      check("timeout_cycles", n, 20);
      check("after_timeout_state", state_dbg, (k < 2) ? 3 : 7);
    end
    check("fail_error", error, 1);
    check("fail_ready", ready, 0);
    repeat (5) tick();
    check("fail_holds", state_dbg, 7);
    pulse_start();
    check("restart_state", state_dbg, 1);
    check("restart_error_clear", error, 0);
    tick();

    check("tx_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wifi_at_sequencer.md
# wifi_at_sequencer

Sequences the ESP8266 WiFi module on the DE10-Nano WiFi switch reader: pulses the module's reset, waits for boot, sends a fixed AT init script over the WiFi UART byte interface, and confirms each command with an `OK\r\n` response under timeout and retry. Once initialised, it reports every change of the 4-bit switch input as an ASCII command. It sits between the switch/key PIO inputs and the byte-level WiFi UART (TX/RX plus CTS flow control) and replaces software sequencing of the reset PIO.

## Interface
Parameters:
- RESET_CYCLES, 5_000_000 — wifi_reset_n low time (100 ms @ 50 MHz)
- BOOT_CYCLES, 100_000_000 — wait after reset release before first command
- TIMEOUT_CYCLES, 50_000_000 — max wait for `OK\r\n` after last command byte accepted
- MAX_RETRY, 3 — resends per command before failure

Ports:
- clk_clk  in  1  system clock; single clock domain
- reset_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; (re)starts full sequence from any state
- sw  in  4  raw switch inputs; asynchronous, synchronised internally
- wifi_reset_n  out  1  module reset, active low
- tx_data  out  8  byte to UART
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts byte when tx_valid & tx_ready
- cts_n  in  1  module clear-to-send, active low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe per received byte
- ready  out  1  init complete; idle or reporting
- error  out  1  retries exhausted; sticky until start/reset
- state_dbg  out  3  current state encoding, for seg7/LED debug

## Operation
- States: IDLE(0), RST(1), BOOT(2), SEND(3), WAIT_OK(4), READY(5), REPORT(6), FAIL(7).
- IDLE: waits for start. start in any state -> RST, clears retry count, error, ready, and the matcher; an in-flight tx_valid drops immediately (the only case where valid is withdrawn).
- RST: wifi_reset_n=0 for RESET_CYCLES, then -> BOOT. BOOT: counts BOOT_CYCLES -> SEND with cmd index 0.
- Init script: cmd 0 `AT\r\n`, cmd 1 `ATE0\r\n`. SEND streams the current command bytes; after the last byte accepted -> WAIT_OK.
- WAIT_OK: a 4-byte rx shift register (cleared on entry) matches `OK\r\n` -> advance. Next init cmd -> SEND; after the last init cmd -> READY, ready=1. After a report -> READY.
- Timeout in WAIT_OK: retry<MAX_RETRY -> retry++, resend the same command (SEND). Otherwise -> FAIL, error=1, ready=0. Retry count resets on each successful OK.
- READY: 2-flop-synchronised sw compared to last_sent (reset 4'h0). On mismatch, latch snapshot -> REPORT, which sends `S=<hex>\r\n` (hex digit '0'-'9','A'-'F' of the snapshot), then WAIT_OK. last_sent is updated only on OK.
- sw changes during a report are picked up on return to READY.
- rx bytes outside WAIT_OK are ignored.
- FAIL holds until start.

## Timing
- Reset values: state IDLE, wifi_reset_n=1, tx_valid=0, tx_data=0, ready=0, error=0, all counters 0.
- All outputs registered; a state change is visible the cycle after its cause.
- TX: tx_valid rises only while cts_n is low. Once high, tx_valid and tx_data are held until accepted, regardless of cts_n. Next byte presented the cycle after acceptance; max 1 byte/cycle.
- Timeout counter starts the cycle after the last byte is accepted and fires when it reaches TIMEOUT_CYCLES-1. An OK completing in the same cycle as the timeout wins.
- start coincident with any other event wins. reset_reset overrides start.
- sw path latency: 2 cycles sync + 1 cycle compare before REPORT.

## Structure
- Package wifi_at_pkg: state enum, command ROM bytes and per-command start/length constants, ASCII constants (`O`,`K`,CR,LF,`S`,`=`), and the hex-to-ASCII function.
- Sub-module wifi_ok_matcher: rx shift register + compare, with clear input and one-cycle match pulse.

## Test plan
All tests use RESET_CYCLES=4, BOOT_CYCLES=8, TIMEOUT_CYCLES=20, MAX_RETRY=2, with a UART model that has tx_ready always 1 and cts_n=0 unless stated.
- Start pulse, model replies `OK\r\n` after each command -> wifi_reset_n low exactly 4 cycles; bytes `AT\r\nATE0\r\n` observed; ready=1, state_dbg=5.
- After ready, sw=4'hA -> bytes `S=A\r\n`; reply OK -> back to READY; sw stable -> no further TX.
- No reply to `AT\r\n` -> sent 3 times, 20 cycles apart from last byte; then error=1, state_dbg=7, ready=0. Subsequent start -> RST, error=0.
- cts_n=1 during SEND -> tx_valid stays 0. cts_n asserted with tx_ready=0 for 5 cycles -> tx_data held stable until accepted, no byte lost or duplicated.
- Reply `OK\r` then garbage then `OK\r\n` -> matches only on the final LF. Reply ends exactly on the timeout cycle -> treated as success.
- start pulse mid-REPORT -> tx_valid drops the next cycle, wifi_reset_n=0, last_sent unchanged.
